// File: rtl/dpll_pkg.sv
// Shared types and defaults for the DPSK bit-synchroniser DPLL correction path.
package dpll_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND_ADD = 2'd1,
        PEND_DED = 2'd2
    } corr_state_e;

    localparam int DIV_N_DEF    = 8;
    localparam int LOCK_CNT_DEF = 16;
    localparam int LOSS_CNT_DEF = 4;

    function automatic int phase_w(input int div_n);
        return (div_n > 1) ? $clog2(div_n) : 1;
    endfunction

endpackage

// File: rtl/dpll_lock_det.sv
// Lock qualifier: counts consecutive quiet / corrected bit periods at each wrap.
module dpll_lock_det
    import dpll_pkg::*;
#(
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int LOSS_CNT = LOSS_CNT_DEF
) (
    input  logic clk32_i,
    input  logic rst_n_i,
    input  logic i_en,
    input  logic i_wrap,
    input  logic i_period_had_corr,
    output logic o_lock
);

    localparam int QW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    logic [QW-1:0] r_quiet, w_quiet_nxt;
    logic [BW-1:0] r_busy,  w_busy_nxt;
    logic          r_lock,  w_lock_nxt;

    always_comb begin
        w_quiet_nxt = r_quiet;
        w_busy_nxt  = r_busy;
        w_lock_nxt  = r_lock;
        if (i_wrap) begin
            if (i_period_had_corr) begin
                w_quiet_nxt = '0;
                w_busy_nxt  = (r_busy >= BW'(LOSS_CNT)) ? r_busy : r_busy + 1'b1;
                if (w_busy_nxt == BW'(LOSS_CNT)) w_lock_nxt = 1'b0;
            end else begin
                w_busy_nxt  = '0;
                w_quiet_nxt = (r_quiet >= QW'(LOCK_CNT)) ? r_quiet : r_quiet + 1'b1;
                if (w_quiet_nxt == QW'(LOCK_CNT)) w_lock_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk32_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_quiet <= '0;
            r_busy  <= '0;
            r_lock  <= 1'b0;
        end else if (!i_en) begin
            r_quiet <= '0;
            r_busy  <= '0;
            r_lock  <= 1'b0;
        end else begin
            r_quiet <= w_quiet_nxt;
            r_busy  <= w_busy_nxt;
            r_lock  <= w_lock_nxt;
        end
    end

    assign o_lock = r_lock;

endmodule

// File: rtl/dpll_corr_ctrl.sv
// DPLL add/deduct controller: one strobe correction per bit period, /DIV_N bit clock, lock status.
module dpll_corr_ctrl
    import dpll_pkg::*;
#(
    parameter int DIV_N    = DIV_N_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int LOSS_CNT = LOSS_CNT_DEF
) (
    input  logic                        clk32_i,
    input  logic                        rst_n_i,
    input  logic                        en_i,
    input  logic                        clk_d1_i,
    input  logic                        clk_d2_i,
    input  logic                        lead_i,
    input  logic                        lag_i,
    output logic                        bitclk_o,
    output logic [phase_w(DIV_N)-1:0]   bit_phase_o,
    output logic                        corr_add_o,
    output logic                        corr_ded_o,
    output logic                        conflict_o,
    output logic                        lock_o
);

    localparam int PW = phase_w(DIV_N);

    corr_state_e   r_state, w_state_nxt;
    logic          r_corr_used, w_used_nxt;
    logic [PW-1:0] r_phase;
    logic          r_bitclk, r_add, r_ded, r_conflict, r_had_corr;

    logic w_ded_fire, w_add_fire, w_count_en, w_wrap, w_used_eff;
    logic w_req_ded, w_req_add, w_corr_now;

    // d1 wins when both strobes coincide, so an add can only fire on a lone d2.
    assign w_ded_fire = (r_state == PEND_DED) & clk_d1_i;
    assign w_add_fire = (r_state == PEND_ADD) & clk_d2_i & ~clk_d1_i;
    assign w_count_en = (clk_d1_i & ~w_ded_fire) | w_add_fire;
    assign w_wrap     = w_count_en & (r_phase == PW'(DIV_N - 1));

    // A wrap in the same cycle opens the new period before the request is judged.
    assign w_used_eff = r_corr_used & ~w_wrap;
    assign w_req_ded  = lead_i & ~lag_i & ~w_used_eff;
    assign w_req_add  = lag_i & ~lead_i & ~w_used_eff;
    assign w_corr_now = r_had_corr | w_ded_fire | w_add_fire;

    always_comb begin
        w_state_nxt = r_state;
        w_used_nxt  = w_used_eff;
        case (r_state)
            IDLE: begin
                if (w_req_ded) begin
                    w_state_nxt = PEND_DED;
                    w_used_nxt  = 1'b1;
                end else if (w_req_add) begin
                    w_state_nxt = PEND_ADD;
                    w_used_nxt  = 1'b1;
                end
            end
            PEND_DED: if (w_ded_fire) w_state_nxt = IDLE;
            PEND_ADD: if (w_add_fire) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk32_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_corr_used <= 1'b0;
        end else if (!en_i) begin
            r_state     <= IDLE;
            r_corr_used <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_corr_used <= w_used_nxt;
        end
    end

    always_ff @(posedge clk32_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_phase    <= '0;
            r_bitclk   <= 1'b0;
            r_add      <= 1'b0;
            r_ded      <= 1'b0;
            r_conflict <= 1'b0;
            r_had_corr <= 1'b0;
        end else if (!en_i) begin
            r_phase    <= '0;
            r_bitclk   <= 1'b0;
            r_add      <= 1'b0;
            r_ded      <= 1'b0;
            r_conflict <= 1'b0;
            r_had_corr <= 1'b0;
        end else begin
            if (w_count_en) r_phase <= w_wrap ? '0 : r_phase + 1'b1;
            r_bitclk   <= w_wrap;
            r_add      <= w_add_fire;
            r_ded      <= w_ded_fire;
            r_conflict <= lead_i & lag_i;
            r_had_corr <= w_wrap ? 1'b0 : w_corr_now;
        end
    end

    dpll_lock_det #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) u_lock_det (
        .clk32_i           (clk32_i),
        .rst_n_i           (rst_n_i),
        .i_en              (en_i),
        .i_wrap            (w_wrap),
        .i_period_had_corr (w_corr_now),
        .o_lock            (lock_o)
    );

    assign bitclk_o    = r_bitclk;
    assign bit_phase_o = r_phase;
    assign corr_add_o  = r_add;
    assign corr_ded_o  = r_ded;
    assign conflict_o  = r_conflict;

endmodule

// File: tb/tb_dpll_corr_ctrl.sv
// Self-checking bench for dpll_corr_ctrl: directed period scenarios plus a randomized model comparison.
module tb_dpll_corr_ctrl;
    import dpll_pkg::*;

    localparam int DIV_N    = 8;
    localparam int LOCK_CNT = 16;
    localparam int LOSS_CNT = 4;
    localparam int PW       = phase_w(DIV_N);

    logic          clk32_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          en_i = 1'b0;
    logic          clk_d1_i = 1'b0;
    logic          clk_d2_i = 1'b0;
    logic          lead_i = 1'b0;
    logic          lag_i = 1'b0;
    logic          bitclk_o;
    logic [PW-1:0] bit_phase_o;
    logic          corr_add_o, corr_ded_o, conflict_o, lock_o;

    int vectors = 0;
    int miscompares = 0;
    int q = 0;

    // Reference model state: pend 0=none, 1=add pending, 2=deduct pending.
    int m_pend = 0, m_used = 0, m_cnt = 0, m_had = 0;
    int m_quiet = 0, m_busy = 0, m_lock = 0;
    int e_bitclk = 0, e_add = 0, e_ded = 0, e_conf = 0;

    dpll_corr_ctrl #(.DIV_N(DIV_N), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .clk32_i     (clk32_i),
        .rst_n_i     (rst_n_i),
        .en_i        (en_i),
        .clk_d1_i    (clk_d1_i),
        .clk_d2_i    (clk_d2_i),
        .lead_i      (lead_i),
        .lag_i       (lag_i),
        .bitclk_o    (bitclk_o),
        .bit_phase_o (bit_phase_o),
        .corr_add_o  (corr_add_o),
        .corr_ded_o  (corr_ded_o),
        .conflict_o  (conflict_o),
        .lock_o      (lock_o)
    );

    always #5 clk32_i = ~clk32_i;

    task automatic model_step();
        int ded_f, add_f, cnt, wrap, used_now, had;
        if (!rst_n_i || !en_i) begin
            m_pend = 0; m_used = 0; m_cnt = 0; m_had = 0;
            m_quiet = 0; m_busy = 0; m_lock = 0;
            e_bitclk = 0; e_add = 0; e_ded = 0; e_conf = 0;
            return;
        end
        ded_f = (m_pend == 2 && clk_d1_i) ? 1 : 0;
        add_f = (m_pend == 1 && clk_d2_i && !clk_d1_i) ? 1 : 0;
        cnt   = ((clk_d1_i && !ded_f) || add_f) ? 1 : 0;
        wrap  = (cnt && m_cnt == DIV_N - 1) ? 1 : 0;
        e_bitclk = wrap; e_add = add_f; e_ded = ded_f;
        e_conf   = (lead_i && lag_i) ? 1 : 0;
        used_now = (m_used && !wrap) ? 1 : 0;
        if (m_pend == 0 && !used_now && (lead_i != lag_i)) begin
            m_pend = lead_i ? 2 : 1;
            m_used = 1;
        end else begin
            if (ded_f || add_f) m_pend = 0;
            m_used = used_now;
        end
        had = (m_had || ded_f || add_f) ? 1 : 0;
        if (wrap) begin
            if (had) begin
                m_quiet = 0;
                m_busy  = (m_busy < LOSS_CNT) ? m_busy + 1 : m_busy;
                if (m_busy == LOSS_CNT) m_lock = 0;
            end else begin
                m_busy  = 0;
                m_quiet = (m_quiet < LOCK_CNT) ? m_quiet + 1 : m_quiet;
                if (m_quiet == LOCK_CNT) m_lock = 1;
            end
            m_had = 0;
        end else begin
            m_had = had;
        end
        if (cnt) m_cnt = (m_cnt + 1) % DIV_N;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk32_i);
        #1;
        q = (q + 1) % 4;
        clk_d1_i = (q == 0);
        clk_d2_i = (q == 2);
        lead_i = 1'b0;
        lag_i  = 1'b0;
    endtask

    // Runs from just after one bitclk up to the next; pulse indices count edges from 1.
    task automatic measure_period(input int lead_at, input int lag_at, input int lag2_at,
                                  input int both_at, output int len, output int nadd,
                                  output int nded, output int nconf);
        len = -1; nadd = 0; nded = 0; nconf = 0;
        for (int i = 1; i <= 200; i++) begin
            if (i == lead_at) lead_i = 1'b1;
            if (i == lag_at || i == lag2_at) lag_i = 1'b1;
            if (i == both_at) begin lead_i = 1'b1; lag_i = 1'b1; end
            tick();
            nadd  += int'(corr_add_o);
            nded  += int'(corr_ded_o);
            nconf += int'(conflict_o);
            if (bitclk_o) begin
                len = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; en_i = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({bitclk_o, corr_add_o, corr_ded_o, conflict_o, lock_o} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {bitclk_o, corr_add_o, corr_ded_o, conflict_o, lock_o});
        end
        vectors++;
        if (bit_phase_o !== '0) begin
            miscompares++;
            $display("FAIL reset_phase: got %0d expected 0", bit_phase_o);
        end
        rst_n_i = 1'b1;
    endtask

    task automatic test_free_run();
        int len, na, nd, nc, corr_total;
        corr_total = 0;
        for (int w = 1; w <= 16; w++) begin
            measure_period(0, 0, 0, 0, len, na, nd, nc);
            corr_total += na + nd + nc;
            vectors++;
            if (lock_o !== (w == 16)) begin
                miscompares++;
                $display("FAIL free_lock wrap %0d: got %b expected %b", w, lock_o, (w == 16));
            end
            if (w > 1) begin
                vectors++;
                if (len !== 32) begin
                    miscompares++;
                    $display("FAIL free_period wrap %0d: got %0d expected 32", w, len);
                end
            end
        end
        vectors++;
        if (corr_total !== 0) begin
            miscompares++;
            $display("FAIL free_corr: got %0d strobes expected 0", corr_total);
        end
    endtask

    task automatic test_lead();
        int len, na, nd, nc;
        measure_period(8, 0, 0, 0, len, na, nd, nc);
        vectors++;
        if (len !== 36 || nd !== 1 || na !== 0) begin
            miscompares++;
            $display("FAIL lead_period: got len %0d ded %0d add %0d expected 36 1 0", len, nd, na);
        end
        measure_period(0, 0, 0, 0, len, na, nd, nc);
        vectors++;
        if (len !== 32) begin
            miscompares++;
            $display("FAIL lead_after: got %0d expected 32", len);
        end
    endtask

    task automatic test_lag();
        int len, na, nd, nc;
        measure_period(0, 8, 0, 0, len, na, nd, nc);
        vectors++;
        if (len !== 28 || na !== 1 || nd !== 0) begin
            miscompares++;
            $display("FAIL lag_period: got len %0d add %0d ded %0d expected 28 1 0", len, na, nd);
        end
    endtask

    task automatic test_back_to_back();
        int len, na, nd, nc;
        measure_period(0, 8, 16, 0, len, na, nd, nc);
        vectors++;
        if (len !== 28 || na !== 1) begin
            miscompares++;
            $display("FAIL double_lag: got len %0d add %0d expected 28 1", len, na);
        end
        measure_period(0, 8, 0, 0, len, na, nd, nc);
        vectors++;
        if (len !== 28 || na !== 1) begin
            miscompares++;
            $display("FAIL lag_after_wrap: got len %0d add %0d expected 28 1", len, na);
        end
    endtask

    task automatic test_conflict();
        int len, na, nd, nc;
        measure_period(0, 0, 0, 8, len, na, nd, nc);
        vectors++;
        if (len !== 32 || nc !== 1 || (na + nd) !== 0) begin
            miscompares++;
            $display("FAIL conflict: got len %0d conf %0d corr %0d expected 32 1 0", len, nc, na + nd);
        end
    endtask

    task automatic test_lock_loss();
        int len, na, nd, nc;
        vectors++;
        if (lock_o !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_before_loss: got %b expected 1", lock_o);
        end
        for (int k = 1; k <= 4; k++) begin
            measure_period(8, 0, 0, 0, len, na, nd, nc);
            vectors++;
            if (lock_o !== (k < 4)) begin
                miscompares++;
                $display("FAIL lock_loss period %0d: got %b expected %b", k, lock_o, (k < 4));
            end
        end
    endtask

    task automatic test_reset_mid_corr();
        int nded;
        repeat (7) tick();
        lead_i = 1'b1;
        tick();
        tick();
        rst_n_i = 1'b0;
        #1;
        vectors++;
        if ({bitclk_o, corr_add_o, corr_ded_o, conflict_o, lock_o} !== 5'b0 || bit_phase_o !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got %b phase %0d expected all 0",
                     {bitclk_o, corr_add_o, corr_ded_o, conflict_o, lock_o}, bit_phase_o);
        end
        repeat (2) tick();
        rst_n_i = 1'b1;
        nded = 0;
        repeat (40) begin
            tick();
            nded += int'(corr_ded_o);
        end
        vectors++;
        if (nded !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_ded: got %0d strobes expected 0", nded);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            lead_i = ($urandom_range(0, 11) == 0);
            lag_i  = ($urandom_range(0, 11) == 0);
            en_i   = ($urandom_range(0, 199) != 0);
            tick();
            vectors++;
            if (bitclk_o !== e_bitclk[0] || int'(bit_phase_o) !== m_cnt || corr_add_o !== e_add[0] ||
                corr_ded_o !== e_ded[0] || conflict_o !== e_conf[0] || lock_o !== m_lock[0]) begin
                miscompares++;
                $display("FAIL random cycle %0d: got bclk %b ph %0d add %b ded %b conf %b lock %b expected %0d %0d %0d %0d %0d %0d",
                         n, bitclk_o, bit_phase_o, corr_add_o, corr_ded_o, conflict_o, lock_o,
                         e_bitclk, m_cnt, e_add, e_ded, e_conf, m_lock);
            end
        end
        en_i = 1'b1;
    endtask

    initial begin
        clk_d1_i = 1'b1;
        clk_d2_i = 1'b0;
        test_reset();
        test_free_run();
        test_lead();
        test_lag();
        test_back_to_back();
        test_conflict();
        test_lock_loss();
        test_reset_mid_corr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
